// File: rtl/control_unit_pkg.sv
// Shared definitions for the 8-bit CPU instruction decoder.
//
// Contents: ISA field widths, opcode constants, the ALU-class marker bit,
// the R0 register select, the control-word struct and a small helper
// that extracts the opcode field from an instruction byte.
//
// Optional feature macro: CONTROL_UNIT_ILLEGAL_EN. When it is defined, the
// control word carries an extra 'illegal' flag for undefined opcodes.
package control_unit_pkg;

  localparam int INST_W    = 8;
  localparam int ALU_SEL_W = 4;
  localparam int REG_SEL_W = 3;
  localparam int OPCODE_W  = 5;

  localparam logic [OPCODE_W-1:0] OP_NOP         = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_MOV_TO_R0   = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_MOV_FROM_R0 = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_LDC         = 5'b00011;

  // Instructions with this bit set are ALU operations R0 <- R0 op Rr.
  localparam int ALU_CLASS_BIT = 7;

  localparam logic [REG_SEL_W-1:0] REG_R0 = 3'b000;

  typedef struct packed {
    logic [ALU_SEL_W-1:0] alu_sel;
    logic [REG_SEL_W-1:0] reg_in_sel;
    logic [REG_SEL_W-1:0] reg_out_sel;
    logic                 reg_in_en;
    logic                 reg_out_en;
    logic                 gen_const;
`ifdef CONTROL_UNIT_ILLEGAL_EN
    logic                 illegal;
`endif
  } ctrl_word_t;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INST_W-1:0] inst);
    return inst[INST_W-1 -: OPCODE_W];
  endfunction

endpackage

// File: rtl/control_decode.sv
// Purely combinational instruction decoder: instruction byte -> control word.
//
// Ports:
//   inst  in   8  instruction byte (opcode in [7:3], register field in [2:0])
//   word  out  control word (ctrl_word_t)
//
// Optional feature macro: CONTROL_UNIT_ILLEGAL_EN (sets word.illegal for
// undefined opcodes; their control word is still a NOP).
module control_decode
  import control_unit_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  output ctrl_word_t        word
);

  logic [OPCODE_W-1:0]  opcode;
  logic [REG_SEL_W-1:0] r;

  assign opcode = opcode_of(inst);
  assign r      = inst[REG_SEL_W-1:0];

  always_comb begin
    word = '0;
    if (inst[ALU_CLASS_BIT]) begin
      // The four bits below the class marker are the ALU function itself.
      word.alu_sel     = inst[ALU_CLASS_BIT-1 -: ALU_SEL_W];
      word.reg_in_sel  = REG_R0;
      word.reg_out_sel = r;
      word.reg_in_en   = 1'b1;
      word.reg_out_en  = 1'b1;
    end else begin
      case (opcode)
        OP_NOP: begin
        end
        OP_MOV_TO_R0: begin
          word.reg_in_sel  = REG_R0;
          word.reg_out_sel = r;
          word.reg_in_en   = 1'b1;
          word.reg_out_en  = 1'b1;
        end
        OP_MOV_FROM_R0: begin
          word.reg_in_sel  = r;
          word.reg_out_sel = REG_R0;
          word.reg_in_en   = 1'b1;
          word.reg_out_en  = 1'b1;
        end
        OP_LDC: begin
          // The constant generator owns the bus, so the register file
          // must not drive it.
          word.gen_const  = 1'b1;
          word.reg_in_sel = r;
          word.reg_in_en  = 1'b1;
        end
        default: begin
          // Opcodes 00100..01111 behave as NOP.
`ifdef CONTROL_UNIT_ILLEGAL_EN
          word.illegal = 1'b1;
`endif
        end
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Registered instruction decoder for the 8-bit CPU. Decodes the current
// instruction into the datapath control word and holds it in flops so it
// is stable for a full cycle (1-cycle latency).
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous active-high reset; zeroes all outputs
//   inst       in   8  current instruction byte
//   aluSel     out  4  ALU function select
//   regInSel   out  3  register written from the bus
//   regOutSel  out  3  register driving the bus
//   regInEn    out  1  register-file write enable
//   regOutEn   out  1  register-file bus-drive enable
//   genConst   out  1  constant generator drives the bus
//   illegalOp  out  1  undefined opcode flag (only with CONTROL_UNIT_ILLEGAL_EN)
//
// Optional feature macro: CONTROL_UNIT_ILLEGAL_EN.
module control_unit
  import control_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INST_W-1:0]    inst,
  output logic [ALU_SEL_W-1:0] aluSel,
  output logic [REG_SEL_W-1:0] regInSel,
  output logic [REG_SEL_W-1:0] regOutSel,
  output logic                 regInEn,
  output logic                 regOutEn,
`ifdef CONTROL_UNIT_ILLEGAL_EN
  output logic                 illegalOp,
`endif
  output logic                 genConst
);

  ctrl_word_t word_p0;
  ctrl_word_t word_p1;

  control_decode u_decode (
    .inst (inst),
    .word (word_p0)
  );

  // Stage p0 -> p1: combinational decode registered into the output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_p1 <= '0;
    end else begin
      word_p1 <= word_p0;
    end
  end

  assign aluSel    = word_p1.alu_sel;
  assign regInSel  = word_p1.reg_in_sel;
  assign regOutSel = word_p1.reg_out_sel;
  assign regInEn   = word_p1.reg_in_en;
  assign regOutEn  = word_p1.reg_out_en;
  assign genConst  = word_p1.gen_const;
`ifdef CONTROL_UNIT_ILLEGAL_EN
  assign illegalOp = word_p1.illegal;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: applies hand-decoded instructions and
// checks the registered control word one cycle later.
// Optional feature macro: CONTROL_UNIT_ILLEGAL_EN (also checks illegalOp).
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [7:0] inst;
  logic [3:0] aluSel;
  logic [2:0] regInSel;
  logic [2:0] regOutSel;
  logic       regInEn;
  logic       regOutEn;
  logic       genConst;
`ifdef CONTROL_UNIT_ILLEGAL_EN
  logic       illegalOp;
`endif

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .clk       (clk),
    .rst       (rst),
    .inst      (inst),
    .aluSel    (aluSel),
    .regInSel  (regInSel),
    .regOutSel (regOutSel),
    .regInEn   (regInEn),
    .regOutEn  (regOutEn),
`ifdef CONTROL_UNIT_ILLEGAL_EN
    .illegalOp (illegalOp),
`endif
    .genConst  (genConst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed word layout: {aluSel, regInSel, regOutSel, regInEn, regOutEn, genConst}
  task automatic check(input string tag, input logic [3:0] a, input logic [2:0] ri,
                       input logic [2:0] ro, input logic ie, input logic oe,
                       input logic gc);
    logic [12:0] got;
    logic [12:0] exp;
    got = {aluSel, regInSel, regOutSel, regInEn, regOutEn, genConst};
    exp = {a, ri, ro, ie, oe, gc};
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s got=%b expected=%b", tag, got, exp);
      $error("%s observed %b expected %b", tag, got, exp);
    end
    checks++;
    assert (!(genConst === 1'b1 && regOutEn === 1'b1)) else begin
      errors++;
      $display("FAIL %s_bus_conflict genConst=%b regOutEn=%b expected not both 1",
               tag, genConst, regOutEn);
      $error("%s bus conflict", tag);
    end
  endtask

`ifdef CONTROL_UNIT_ILLEGAL_EN
  task automatic check_ill(input string tag, input logic exp);
    checks++;
    assert (illegalOp === exp) else begin
      errors++;
      $display("FAIL %s illegalOp got=%b expected=%b", tag, illegalOp, exp);
      $error("%s illegalOp observed %b expected %b", tag, illegalOp, exp);
    end
  endtask
`endif

  task automatic step(input logic r, input logic [7:0] i);
    rst  = r;
    inst = i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    inst = 8'hFF;

    step(1'b1, 8'hFF);
    check("reset_ff", 4'b0000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
`ifdef CONTROL_UNIT_ILLEGAL_EN
    check_ill("reset_ff", 1'b0);
`endif

    step(1'b0, 8'h00);
    check("nop", 4'b0000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

    step(1'b0, 8'b00001_011);
    check("mov_to_r0_r3", 4'b0000, 3'b000, 3'b011, 1'b1, 1'b1, 1'b0);

    // Output must hold between edges even when inst changes.
    inst = 8'b00011_111;
    #3;
    check("hold", 4'b0000, 3'b000, 3'b011, 1'b1, 1'b1, 1'b0);

    step(1'b0, 8'b00010_101);
    check("mov_from_r0_r5", 4'b0000, 3'b101, 3'b000, 1'b1, 1'b1, 1'b0);

    step(1'b0, 8'b00011_110);
    check("ldc_r6", 4'b0000, 3'b110, 3'b000, 1'b1, 1'b0, 1'b1);

    step(1'b0, 8'b1_0110_010);
    check("alu_6_r2", 4'b0110, 3'b000, 3'b010, 1'b1, 1'b1, 1'b0);

    step(1'b0, 8'b01010_111);
    check("undef_01010", 4'b0000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
`ifdef CONTROL_UNIT_ILLEGAL_EN
    check_ill("undef_01010", 1'b1);
`endif

    step(1'b1, 8'b00001_011);
    check("reset_mid", 4'b0000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

    step(1'b0, 8'b00001_011);
    check("after_reset", 4'b0000, 3'b000, 3'b011, 1'b1, 1'b1, 1'b0);

    step(1'b0, 8'b00001_000);
    check("mov_r0_r0", 4'b0000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);

    step(1'b0, 8'b00011_000);
    check("ldc_r0", 4'b0000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1);

    step(1'b0, 8'b00010_001);
    check("mov_from_r0_r1", 4'b0000, 3'b001, 3'b000, 1'b1, 1'b1, 1'b0);

    step(1'b0, 8'b1_1111_111);
    check("alu_f_r7", 4'b1111, 3'b000, 3'b111, 1'b1, 1'b1, 1'b0);

    step(1'b0, 8'b1_0000_000);
    check("alu_0_r0", 4'b0000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);

    step(1'b0, 8'b00100_101);
    check("undef_00100", 4'b0000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
`ifdef CONTROL_UNIT_ILLEGAL_EN
    check_ill("undef_00100", 1'b1);
`endif

    step(1'b0, 8'b01111_011);
    check("undef_01111", 4'b0000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

    step(1'b0, 8'b00000_111);
    check("nop_r7", 4'b0000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
`ifdef CONTROL_UNIT_ILLEGAL_EN
    check_ill("nop_r7", 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Instruction decoder for the 8-bit CPU.
- Takes the current 8-bit instruction and produces the datapath control word:
  - ALU function select
  - register-file write/read selects and enables
  - constant-generator enable
- Sits between the instruction register and the datapath (register file, ALU, bus).
- Control word is registered, so it is stable for a full cycle.

Parameters:
- None. All widths are fixed by the ISA: 8-bit instruction, 4-bit ALU select, 3-bit register select.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- inst  input  8  current instruction byte
- aluSel  output  4  ALU function select
- regInSel  output  3  register written from the bus
- regOutSel  output  3  register driving the bus
- regInEn  output  1  register-file write enable
- regOutEn  output  1  register-file bus-drive enable
- genConst  output  1  constant generator drives the bus

Behaviour:
- Instruction format: inst[7:3] = opcode, inst[2:0] = r (register field).
- Every output is a flop. Control word for the inst sampled at rising edge N is visible after edge N and holds until edge N+1. Latency is 1 cycle; no handshake.
- Reset: on any rising edge with rst=1, all outputs become 0 regardless of inst (e.g. inst=8'hFF). Reset asserted mid-stream zeroes the word on that edge. The first edge after rst falls decodes normally.
- Decode table (fields not listed are 0):
  - 00000 rrr, NOP: all outputs 0.
  - 00001 rrr, MOV R0<-Rr: regInSel=000, regOutSel=r, regInEn=1, regOutEn=1.
  - 00010 rrr, MOV Rr<-R0: regInSel=r, regOutSel=000, regInEn=1, regOutEn=1.
  - 00011 rrr, LDC Rr: genConst=1, regInSel=r, regInEn=1, regOutEn=0, regOutSel=000. The constant is r zero-extended and is produced by the datapath.
  - 1aaaa rrr, ALU R0<-R0 op Rr: aluSel=aaaa, regInSel=000, regOutSel=r, regInEn=1, regOutEn=1.
  - 00100–01111 (undefined): decoded exactly as NOP.
- Invariant: genConst and regOutEn are never both 1.
- r=000 is legal in every form (e.g. MOV R0<-R0).

Optional Feature:
- Macro: CONTROL_UNIT_ILLEGAL_EN.
- When defined:
  - Adds output port illegalOp (1 bit, registered, same timing as the control word).
  - illegalOp=1 for opcodes 00100–01111; 0 otherwise.
  - illegalOp is 0 on reset.
  - Control word for undefined opcodes is still NOP.
- When not defined: the port and its logic do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - opcode constants: OP_NOP=5'b00000, OP_MOV_TO_R0=5'b00001, OP_MOV_FROM_R0=5'b00010, OP_LDC=5'b00011
  - ALU-class marker (inst[7]=1)
  - REG_R0=3'b000
  - widths: INST_W=8, ALU_SEL_W=4, REG_SEL_W=3
  - a control-word struct/typedef
- One natural sub-module: control_decode, purely combinational inst -> control word. control_unit wraps it with the reset-able output register.

Test Plan:
- rst=1, inst=8'hFF, one edge -> aluSel=0000, regInSel=000, regOutSel=000, regInEn=0, regOutEn=0, genConst=0.
- rst=0, inst=8'h00, one edge -> all outputs 0.
- inst=8'b00001_011, one edge -> aluSel=0000, regInSel=000, regOutSel=011, regInEn=1, regOutEn=1, genConst=0.
- inst=8'b00010_101 -> regInSel=101, regOutSel=000, both enables 1. Then inst=8'b00011_110 -> genConst=1, regInSel=110, regInEn=1, regOutEn=0.
- inst=8'b1_0110_010 -> aluSel=0110, regOutSel=010, regInSel=000, both enables 1.
- inst=8'b01010_111 -> all outputs 0 (illegalOp=1 when CONTROL_UNIT_ILLEGAL_EN is defined). Then assert rst with inst=8'b00001_011 -> outputs 0 on that edge.
